// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer and FIFO-write-side signals of the round-robin write arbiter
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  full;
  logic                  wr_error;
  logic                  wr_en;
  logic [WIDTH-1:0]      w_data;
  logic [CNT_W-1:0]      err_cnt;
  modport master (
    output req, req_data, full, wr_error,
    input  ack, grant, busy, wr_en, w_data, err_cnt
  );
  modport slave (
    input  req, req_data, full, wr_error,
    output ack, grant, busy, wr_en, w_data, err_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded arbiter sharing one FIFO write port among NREQ producers
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input logic clk,
  input logic rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_n;
  logic [NREQ-1:0] grant, grant_n, ack;
  logic [PW-1:0] ptr, ptr_n, owner, winner;
  logic [BW-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] err_cnt;
  logic found;
  always_comb begin
    owner = '0;
    for (int i = 0; i < NREQ; i++) if (grant[i]) owner = PW'(i);
  end
  // First requester at or above ptr, wrapping; ptr is one past the last owner
  always_comb begin
    winner = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req[(int'(ptr) + k) % NREQ]) begin
        winner = PW'((int'(ptr) + k) % NREQ);
        found = 1'b1;
      end
    end
  end
  assign ack          = (state == BURST && !bus.full && !rst) ? (grant & bus.req) : '0;
  assign bus.ack      = ack;
  assign bus.wr_en    = |ack;
  assign bus.w_data   = bus.wr_en ? bus.req_data[owner*WIDTH +: WIDTH] : '0;
  assign bus.grant    = grant;
  assign bus.busy     = state == BURST;
  assign bus.err_cnt  = err_cnt;
  always_comb begin
    state_n = state;
    grant_n = grant;
    cnt_n = cnt;
    ptr_n = ptr;
    if (state == IDLE) begin
      if (|bus.req) begin
        state_n = BURST;
        grant_n = NREQ'(1) << winner;
        cnt_n = '0;
      end
    end else if (!bus.req[owner] || (ack[owner] && cnt == BW'(MAX_BURST - 1))) begin
      state_n = IDLE;
      grant_n = '0;
      ptr_n = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
    end else if (ack[owner]) begin
      cnt_n = cnt + BW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr <= '0;
      cnt <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      if (bus.wr_error && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end
endmodule
